pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-control stage of the single-cycle core.
- Holds the PC and drives it into instruction memory. Increments it each cycle.
- Loads absolute branch/jump targets supplied by the label-to-target lookup stage (12-bit next_pc).
- Runs the start/halt/done program handshake with the testbench and counts retired instructions.

---
 rtl/pc_fetch_ctrl_if.sv | 40 ++++
 rtl/pc_fetch_ctrl.sv | 95 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: program handshake, branch controls and PC/status outputs.
// With CALL_RET_EN defined it also carries call/ret requests and the link register.
interface pc_fetch_ctrl_if #(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt;
  logic             stall;
  logic             branch_taken;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;
  logic             wrap_err;
  logic [CNT_W-1:0] instr_count;
`ifdef CALL_RET_EN
  logic             call;
  logic             ret;
  logic [PC_W-1:0]  link;
`endif

  modport master (
    output start, halt, stall, branch_taken, target,
    input  pc, running, done, wrap_err, instr_count
`ifdef CALL_RET_EN
    , output call, ret,
    input  link
`endif
  );

  modport slave (
    input  start, halt, stall, branch_taken, target,
    output pc, running, done, wrap_err, instr_count
`ifdef CALL_RET_EN
    , input  call, ret,
    output link
`endif
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control: IDLE/RUN/HALTED handshake, branches, retire count.
// Optional single-entry call/return link register enabled by defining CALL_RET_EN.
module pc_fetch_ctrl #(
  parameter int              PC_W       = 12,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap_q;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             pc_at_max;
`ifdef CALL_RET_EN
  logic [PC_W-1:0]  link_q;
`endif

  assign pc_inc    = pc_q + 1'b1;
  assign pc_at_max = &pc_q;
  // Retire counter sticks at all-ones rather than wrapping.
  assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // NOTE: state is updated with non-blocking assignments so every branch of the
  // case below reads the pre-edge values of pc_q/cnt_q, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc_q   <= START_ADDR;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
`ifdef CALL_RET_EN
      // NOTE: link is reset only here; a start deliberately leaves it alone.
      link_q <= START_ADDR;
`endif
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (bus.start) begin
            state  <= RUN;
            pc_q   <= START_ADDR;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
          end
        end

        RUN: begin
          if (bus.halt) begin
            state <= HALTED;
            cnt_q <= cnt_sat;
          end else if (!bus.stall) begin
            cnt_q <= cnt_sat;
`ifdef CALL_RET_EN
            if (bus.ret) begin
              pc_q <= link_q;
            end else if (bus.call) begin
              link_q <= pc_inc;
              pc_q   <= bus.target;
            end else
`endif
            if (bus.branch_taken) begin
              pc_q <= bus.target;
            end else begin
              pc_q <= pc_inc;
              if (pc_at_max) wrap_q <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_count = cnt_q;
  assign bus.wrap_err    = wrap_q;
  assign bus.running     = (state == RUN);
  assign bus.done        = (state == HALTED);
`ifdef CALL_RET_EN
  assign bus.link        = link_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each task queues expected snapshots as it
// drives stimulus, captures the DUT after the edge, then compares in order.
module tb_pc_fetch_ctrl;
  localparam int PC_W  = 12;
  localparam int CNT_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_fetch_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  pc_fetch_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             done;
    logic             wrap_err;
  } snap_t;

  snap_t exp_q[$];
  snap_t got_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic snap_t mk(input int p, input int c, input bit r, input bit d, input bit w);
    snap_t s;
    s.pc       = p[PC_W-1:0];
    s.cnt      = c[CNT_W-1:0];
    s.running  = r;
    s.done     = d;
    s.wrap_err = w;
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.pc       = bus.pc;
    s.cnt      = bus.instr_count;
    s.running  = bus.running;
    s.done     = bus.done;
    s.wrap_err = bus.wrap_err;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("pc=%0d cnt=%0d run=%0b done=%0b wrap=%0b",
                     s.pc, s.cnt, s.running, s.done, s.wrap_err);
  endfunction

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic step(input bit st, input bit h, input bit s, input bit b, input int t);
    bus.start        = st;
    bus.halt         = h;
    bus.stall        = s;
    bus.branch_taken = b;
    bus.target       = t[PC_W-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit st, input bit h, input bit s, input bit b, input int t,
                       input snap_t e);
    exp_q.push_back(e);
    step(st, h, s, b, t);
    got_q.push_back(observe());
  endtask

  task automatic test_reset();
    snap_t got, want;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    got_q.push_back(observe());
    rst_n = 1'b1;
    // IDLE ignores halt and branch requests
    apply(0, 1, 0, 1, 77, mk(0, 0, 0, 0, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      got = got_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_plain();
    snap_t got, want;
    apply(1, 0, 0, 0, 0, mk(0, 0, 1, 0, 0));
    for (int i = 1; i <= 5; i++) apply(0, 0, 0, 0, 0, mk(i, i, 1, 0, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      got = got_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL plain[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_branch();
    snap_t got, want;
    apply(1, 0, 0, 0, 0, mk(6, 6, 1, 0, 0));     // start ignored in RUN
    apply(0, 1, 0, 0, 0, mk(6, 7, 0, 1, 0));     // halt retires
    apply(1, 0, 0, 0, 0, mk(0, 0, 1, 0, 0));     // start honoured in HALTED
    for (int i = 1; i <= 3; i++) apply(0, 0, 0, 0, 0, mk(i, i, 1, 0, 0));
    apply(0, 0, 0, 1, 347, mk(347, 4, 1, 0, 0));
    apply(0, 0, 0, 0, 0,   mk(348, 5, 1, 0, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      got = got_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL branch[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_stall_halt();
    snap_t got, want;
    apply(0, 0, 0, 1, 10, mk(10, 6, 1, 0, 0));
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 1, 99, mk(10, 6, 1, 0, 0));
    apply(0, 1, 1, 0, 0,  mk(10, 7, 0, 1, 0));   // halt beats stall and still retires
    apply(0, 0, 0, 1, 55, mk(10, 7, 0, 1, 0));   // HALTED holds
    for (int i = 0; exp_q.size() > 0; i++) begin
      got = got_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL stall_halt[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_wrap();
    snap_t got, want;
    apply(1, 0, 0, 0, 0,    mk(0, 0, 1, 0, 0));
    apply(0, 0, 0, 1, 4095, mk(4095, 1, 1, 0, 0));
    apply(0, 0, 0, 1, 4095, mk(4095, 2, 1, 0, 0)); // branch from all-ones: no wrap
    apply(0, 0, 0, 0, 0,    mk(0, 3, 1, 0, 1));
    apply(0, 0, 0, 0, 0,    mk(1, 4, 1, 0, 1));
    apply(0, 1, 0, 0, 0,    mk(1, 5, 0, 1, 1));
    apply(1, 0, 0, 0, 0,    mk(0, 0, 1, 0, 0));    // start clears wrap_err
    for (int i = 0; exp_q.size() > 0; i++) begin
      got = got_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t got, want;
    apply(0, 0, 0, 1, 200, mk(200, 1, 1, 0, 0));
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0));            // before the next rising edge
    got_q.push_back(observe());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));       // back in IDLE, no start
    for (int i = 0; exp_q.size() > 0; i++) begin
      got = got_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL async_reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_saturate();
    snap_t got, want;
    apply(1, 0, 0, 0, 0, mk(0, 0, 1, 0, 0));
    repeat (65540) step(0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, mk(65541 % 4096, 65535, 1, 0, 1));
    apply(0, 1, 0, 0, 0, mk(65541 % 4096, 65535, 0, 1, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      got = got_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL saturate[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

`ifdef CALL_RET_EN
  task automatic test_call_ret();
    snap_t got, want;
    logic [PC_W-1:0] link_after_call;
    apply(1, 0, 0, 0, 0,  mk(0, 0, 1, 0, 0));
    apply(0, 0, 0, 1, 20, mk(20, 1, 1, 0, 0));
    bus.call = 1'b1;
    apply(0, 0, 0, 0, 96, mk(96, 2, 1, 0, 0));
    bus.call = 1'b0;
    link_after_call = bus.link;
    apply(0, 0, 0, 0, 0, mk(97, 3, 1, 0, 0));
    apply(0, 0, 0, 0, 0, mk(98, 4, 1, 0, 0));
    bus.ret = 1'b1;
    apply(0, 0, 0, 1, 500, mk(21, 5, 1, 0, 0));  // ret beats branch
    bus.ret = 1'b0;
    n_cmp++;
    if (link_after_call !== 12'd21) begin
      n_bad++;
      $display("FAIL call_link: got link=%0d, want link=21", link_after_call);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      got = got_q.pop_front(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL call_ret[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start        = 1'b0;
    bus.halt         = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.target       = '0;
`ifdef CALL_RET_EN
    bus.call         = 1'b0;
    bus.ret          = 1'b0;
`endif
    test_reset();
    test_plain();
    test_branch();
    test_stall_halt();
    test_wrap();
    test_async_reset();
    test_saturate();
`ifdef CALL_RET_EN
    test_call_ret();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
